gray_ptr_sync: RTL and testbench

Parametrised successor to the two-flop pointer synchroniser used in the async FIFO. Brings a Gray-coded pointer from the other clock domain into the local `clk` domain through a configurable-depth flop chain. Also provides a registered binary decode, a one-cycle change pulse, a settled/stable indication and a multi-bit-change error check. Sits on both sides of the FIFO (write-pointer into read domain, read-pointer into write domain) and feeds the full/empty logic directly with binary.

---
 rtl/fifo_sync_pkg.sv | 35 +++
 rtl/gray_ptr_sync_chain.sv | 37 +++
 rtl/gray_ptr_sync.sv | 111 +++++++++++
 tb/tb_gray_ptr_sync.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_pkg.sv
// Shared helpers for the async-FIFO pointer synchronisers: Gray/binary conversion,
// popcount and the legal synchroniser depth range.
package fifo_sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Helpers work on a fixed wide word; callers zero-extend and truncate to W bits.
    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [5:0] popcount(input ptr_word_t v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/gray_ptr_sync_chain.sv
// Bare multi-flop synchroniser chain (module sync_chain); kept separate so the
// synchroniser timing constraints can target it alone.
module sync_chain #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s_q [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];

    always_comb begin
        s_d[0] = d;
        for (int k = 1; k < STAGES; k++) begin
            s_d[k] = s_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= s_d[k];
            end
        end
    end

    assign q = s_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Gray pointer synchroniser with registered binary decode, change pulse, stable flag
// and optional multi-bit-step error check (enabled by GRAY_PTR_SYNC_CHECK_EN).
module gray_ptr_sync
    import fifo_sync_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 3,
    localparam int W            = ADDR_WIDTH + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] d_out_gray,
    output logic [W-1:0] d_out_bin,
    output logic         changed,
    output logic         stable,
    input  logic         err_clr,
    output logic         err_multibit
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("gray_ptr_sync: SYNC_STAGES out of range 2..4");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("gray_ptr_sync: STABLE_CYCLES must be >= 1");
    end
    if (W > PTR_MAX_W) begin : g_bad_width
        $error("gray_ptr_sync: pointer width exceeds helper word width");
    end

    logic [W-1:0]     gray_s;
    logic [W-1:0]     prev_q, prev_d;
    logic [W-1:0]     bin_q, bin_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    sync_chain #(
        .WIDTH  (W),
        .STAGES (SYNC_STAGES)
    ) u_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d_in),
        .q     (gray_s)
    );

    always_comb begin
        prev_d    = gray_s;
        bin_d     = W'(gray2bin(PTR_MAX_W'(gray_s)));
        changed_d = (gray_s != prev_q);
        cnt_d     = cnt_q;
        if (changed_d) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '0;
            bin_q     <= '0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            prev_q    <= prev_d;
            bin_q     <= bin_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign d_out_gray = gray_s;
    assign d_out_bin  = bin_q;
    assign changed    = changed_q;
    assign stable     = (cnt_q == CNT_MAX);

`ifdef GRAY_PTR_SYNC_CHECK_EN
    logic err_q, err_d;

    // A new error in the same cycle as err_clr takes priority.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (popcount(PTR_MAX_W'(gray_s ^ prev_q)) > 6'd1) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_multibit = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_multibit   = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Self-checking bench for gray_ptr_sync against an edge-indexed history model.
module tb_gray_ptr_sync;

    localparam int AW = 4;
    localparam int W  = AW + 1;
    localparam int S  = 2;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] d_in;
    logic [W-1:0] d_out_gray;
    logic [W-1:0] d_out_bin;
    logic         changed;
    logic         stable;
    logic         err_clr;
    logic         err_multibit;

    gray_ptr_sync #(
        .ADDR_WIDTH    (AW),
        .SYNC_STAGES   (S),
        .STABLE_CYCLES (ST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .d_in         (d_in),
        .d_out_gray   (d_out_gray),
        .d_out_bin    (d_out_bin),
        .changed      (changed),
        .stable       (stable),
        .err_clr      (err_clr),
        .err_multibit (err_multibit)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // din_at[k] is the d_in value present at edge k after reset release.
    logic [W-1:0] din_at [0:4095];
    int           n;
    logic         ref_err;
    int           bin_of [32];
    int           pulses;

    function automatic logic [W-1:0] gray_at(input int k);
        int j;
        j = k - S + 1;
        return (j >= 1) ? din_at[j] : '0;
    endfunction

    function automatic logic [W-1:0] to_gray(input int b);
        logic [W-1:0] v;
        v = W'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [W-1:0] d, input logic clr);
        logic [W-1:0] g1, g0, g00;
        logic         exp_st;
        d_in    = d;
        err_clr = clr;
        n++;
        din_at[n] = d;
        @(posedge clk);
        #1;
        g1  = gray_at(n);
        g0  = gray_at(n - 1);
        g00 = gray_at(n - 2);
        exp_st = (n >= ST);
        for (int k = n - ST + 1; k <= n; k++) begin
            if (gray_at(k - 1) != gray_at(k - 2)) exp_st = 1'b0;
        end
`ifdef GRAY_PTR_SYNC_CHECK_EN
        if ($countones(g0 ^ g00) > 1) ref_err = 1'b1;
        else if (clr) ref_err = 1'b0;
`else
        ref_err = 1'b0;
`endif
        if (changed === 1'b1) pulses++;
        check("gray",    32'(d_out_gray),   32'(g1));
        check("bin",     32'(d_out_bin),    32'(bin_of[g0]));
        check("changed", 32'(changed),      32'(g0 != g00));
        check("stable",  32'(stable),       32'(exp_st));
        check("err",     32'(err_multibit), 32'(ref_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gray"},    32'(d_out_gray),   32'd0);
        check({tag, "_bin"},     32'(d_out_bin),    32'd0);
        check({tag, "_changed"}, 32'(changed),      32'd0);
        check({tag, "_stable"},  32'(stable),       32'd0);
        check({tag, "_err"},     32'(err_multibit), 32'd0);
    endtask

    task automatic release_reset(input logic [W-1:0] d);
        d_in    = d;
        err_clr = 1'b0;
        n       = 0;
        ref_err = 1'b0;
        rst_n   = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, hold;
        logic [W-1:0] d;
        logic clr;

        for (int i = 0; i < 32; i++) bin_of[i ^ (i >> 1)] = i;

        // Reset held with a nonzero input: everything stays at zero.
        rst_n   = 1'b0;
        err_clr = 1'b0;
        d_in    = 5'b10110;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Release with d_in=0: stable after ST edges, no changed pulse.
        release_reset('0);
        pulses = 0;
        for (int i = 0; i < 6; i++) step('0, 1'b0);
        check("reset_no_pulse", 32'(pulses), 32'd0);

        // Latency: single-bit step 0 -> 1.
        for (int i = 0; i < 7; i++) step(5'b00001, 1'b0);

        // Full wrap: Gray 0..31 then back to 0, five cycles each.
        pulses = 0;
        for (int v = 0; v <= 32; v++) begin
            for (int c = 0; c < 5; c++) step(to_gray(v % 32), 1'b0);
        end
        check("wrap_pulses", 32'(pulses), 32'd33);

        // Multi-bit jump, hold, clear.
        for (int i = 0; i < 4; i++) step('0, 1'b0);
        for (int i = 0; i < 5; i++) step(5'b00011, 1'b0);
        step(5'b00011, 1'b1);
        for (int i = 0; i < 3; i++) step(5'b00011, 1'b0);

        // Clear arrives on the same edge the 00011->01100 jump is compared.
        step(5'b01100, 1'b0);
        step(5'b01100, 1'b0);
        step(5'b01100, 1'b1);
        for (int i = 0; i < 3; i++) step(5'b01100, 1'b0);

        // Randomised walk: mostly single Gray steps, occasional jumps and clears.
        b = 8;
        for (int i = 0; i < 6; i++) step(to_gray(b), 1'b0);
        for (int t = 0; t < 120; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: b = (b + 1) % 32;
                4, 5, 6:    b = (b + 31) % 32;
                default:    b = int'($urandom_range(0, 31));
            endcase
            d    = to_gray(b);
            hold = int'($urandom_range(1, 6));
            for (int c = 0; c < hold; c++) begin
                clr = ($urandom_range(0, 7) == 0);
                step(d, clr);
            end
        end

        // Mid-stream reset while changed is high (and an error is pending if enabled).
        for (int i = 0; i < 4; i++) step(5'b00000, 1'b0);
        step(5'b00011, 1'b0);
        step(5'b00011, 1'b0);
        step(5'b00011, 1'b0);
        check("pre_reset_changed", 32'(changed), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        check_all_zero("midreset_held");

        release_reset(5'b00011);
        for (int i = 0; i < 8; i++) step(5'b00011, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
